// File: rtl/mc_datapath_p.sv
// Multicycle ARM-style datapath with a stall-aware single-request memory port.
// Optional B-operand barrel shifter is enabled by defining DP_SHIFTER_EN.
module mc_datapath_p #(
   parameter int DW     = 32,
   parameter int NREG   = 16,
   parameter int PC_INC = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] ReadData,
   input  logic          mem_ready,
   output logic          mem_valid,
   output logic [DW-1:0] Adr,
   output logic [DW-1:0] WriteData,
   input  logic          PCWrite,
   input  logic          RegWrite,
   input  logic          IRWrite,
   input  logic          FlagWrite,
   input  logic          MemStart,
   input  logic          AdrSrc,
   input  logic [1:0]    RegSrc,
   input  logic [1:0]    ALUSrcA,
   input  logic [1:0]    ALUSrcB,
   input  logic [1:0]    ResultSrc,
   input  logic [1:0]    ImmSrc,
   input  logic [2:0]    ALUControl,
   output logic [DW-1:0] Instr,
   output logic [3:0]    ALUFlags,
   output logic          Stall
);
   localparam int AW = $clog2(NREG);
   localparam logic [AW-1:0] PCR = AW'(NREG - 1);
   localparam logic [AW-1:0] LRR = AW'(NREG - 2);

   logic [DW-1:0] pc_q, ir_q, a_q, b_q, aluout_q, data_q, adr_q;
   logic [DW-1:0] pc_d, ir_d, a_d, b_d, aluout_d, data_d, adr_d;
   logic [3:0]    flags_q, flags_d;
   logic          mv_q, mv_d;
   logic [DW-1:0] rf_q [NREG];

   logic [23:0]        ifld;
   logic signed [23:0] simm;
   logic [AW-1:0]      ra1, ra2, wa;
   logic               we;
   logic [DW-1:0]      rd1, rd2, ext, bop, srca, srcb;
   logic [DW-1:0]      alu_y, result, adr_live;
   logic [DW:0]        sum;
   logic               sh_c, sc, cf, vf;
   logic [3:0]         nzcv;

   // Instruction fields are taken from a 24-bit view so narrow widths still elaborate.
   assign ifld = 24'(ir_q);
   assign simm = ifld;

   assign ra1 = RegSrc[0] ? PCR : AW'(ifld[19:16]);
   assign ra2 = RegSrc[1] ? AW'(ifld[15:12]) : AW'(ifld[3:0]);
   assign rd1 = (ra1 == PCR) ? pc_q : rf_q[ra1];
   assign rd2 = (ra2 == PCR) ? pc_q : rf_q[ra2];

   always_comb begin
      wa = LRR;
      unique case (RegSrc)
         2'b00:   wa = AW'(ifld[15:12]);
         2'b01:   wa = AW'(ifld[3:0]);
         default: wa = LRR;
      endcase
   end

   assign we = RegWrite & ~Stall & (RegSrc != 2'b11) & (wa != PCR);

   always_comb begin
      ext = '0;
      unique case (ImmSrc)
         2'b00:   ext = DW'(ifld[7:0]);
         2'b01:   ext = DW'(ifld[11:0]);
         2'b10:   ext = DW'(simm) << 2;
         default: ext = '0;
      endcase
   end

`ifdef DP_SHIFTER_EN
   localparam int SW = $clog2(DW) + 1;
   logic [SW-1:0]   amt;
   logic [2*DW-1:0] shw;

   always_comb begin
      amt  = SW'(32'(ifld[11:7]) % DW);
      shw  = '0;
      bop  = b_q;
      sh_c = 1'b0;
      unique case (ifld[6:5])
         2'b00: begin
            shw  = {{DW{1'b0}}, b_q} << amt;
            bop  = shw[DW-1:0];
            sh_c = shw[DW];
         end
         2'b01: begin
            shw  = {b_q, {DW{1'b0}}} >> amt;
            bop  = shw[2*DW-1:DW];
            sh_c = shw[DW-1];
         end
         2'b10: begin
            shw  = $signed({b_q, {DW{1'b0}}}) >>> amt;
            bop  = shw[2*DW-1:DW];
            sh_c = shw[DW-1];
         end
         default: begin
            shw  = {b_q, b_q} >> amt;
            bop  = shw[DW-1:0];
            sh_c = bop[DW-1];
         end
      endcase
      if (amt == '0) sh_c = 1'b0;
   end
`else
   assign bop  = b_q;
   assign sh_c = 1'b0;
`endif

   assign sc = sh_c & (ALUSrcB == 2'b00);

   always_comb begin
      srca = '0;
      unique case (ALUSrcA)
         2'b00:   srca = a_q;
         2'b01:   srca = pc_q;
         default: srca = '0;
      endcase
   end

   always_comb begin
      srcb = '0;
      unique case (ALUSrcB)
         2'b00:   srcb = bop;
         2'b01:   srcb = ext;
         2'b10:   srcb = DW'(PC_INC);
         default: srcb = '0;
      endcase
   end

   always_comb begin
      sum   = '0;
      alu_y = '0;
      cf    = 1'b0;
      vf    = 1'b0;
      unique case (ALUControl)
         3'b000: begin
            sum   = {1'b0, srca} + {1'b0, srcb};
            alu_y = sum[DW-1:0];
            cf    = sum[DW];
            vf    = (srca[DW-1] == srcb[DW-1]) & (alu_y[DW-1] != srca[DW-1]);
         end
         3'b001: begin
            sum   = {1'b0, srca} + {1'b0, ~srcb} + (DW+1)'(1);
            alu_y = sum[DW-1:0];
            cf    = sum[DW];
            vf    = (srca[DW-1] != srcb[DW-1]) & (alu_y[DW-1] != srca[DW-1]);
         end
         3'b010: begin alu_y = srca & srcb; cf = sc; end
         3'b011: begin alu_y = srca | srcb; cf = sc; end
         3'b100: begin alu_y = srca ^ srcb; cf = sc; end
         3'b101: begin alu_y = srcb;        cf = sc; end
         default: begin alu_y = srca;       cf = sc; end
      endcase
   end

   assign nzcv = {alu_y[DW-1], alu_y == '0, cf, vf};

   always_comb begin
      result = '0;
      unique case (ResultSrc)
         2'b00:   result = aluout_q;
         2'b01:   result = data_q;
         2'b10:   result = pc_q + DW'(PC_INC);
         default: result = alu_y;
      endcase
   end

   assign adr_live  = AdrSrc ? aluout_q : pc_q;
   assign Adr       = mv_q ? adr_q : adr_live;
   assign Stall     = mv_q & ~mem_ready;
   assign mem_valid = mv_q;
   assign WriteData = b_q;
   assign Instr     = ir_q;
   assign ALUFlags  = flags_q;

   always_comb begin
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      aluout_d = aluout_q;
      data_d   = data_q;
      adr_d    = adr_q;
      flags_d  = flags_q;
      mv_d     = mv_q;
      if (!Stall) begin
         if (PCWrite) pc_d = result;
         a_d      = rd1;
         b_d      = rd2;
         aluout_d = alu_y;
         if (FlagWrite) flags_d = nzcv;
      end
      // A new request is only accepted with the port idle; no queueing.
      if (mv_q) begin
         if (mem_ready) begin
            data_d = ReadData;
            if (IRWrite) ir_d = ReadData;
            mv_d = 1'b0;
         end
      end else if (MemStart) begin
         adr_d = adr_live;
         mv_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
         data_q   <= '0;
         adr_q    <= '0;
         flags_q  <= '0;
         mv_q     <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         a_q      <= a_d;
         b_q      <= b_d;
         aluout_q <= aluout_d;
         data_q   <= data_d;
         adr_q    <= adr_d;
         flags_q  <= flags_d;
         mv_q     <= mv_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) rf_q[wa] <= result;
   end
endmodule

// File: tb/tb_mc_datapath_p.sv
// Randomized self-checking bench for mc_datapath_p against a cycle-level model.
module tb_mc_datapath_p;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ReadData;
   logic        mem_ready;
   logic        mem_valid;
   logic [31:0] Adr, WriteData, Instr;
   logic [3:0]  ALUFlags;
   logic        Stall;
   logic        PCWrite, RegWrite, IRWrite, FlagWrite, MemStart, AdrSrc;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   logic [31:0] m_pc, m_ir, m_a, m_b, m_aluout, m_data, m_adr;
   logic [3:0]  m_flags;
   logic        m_mv;
   logic [31:0] m_regs [16];

   always #5 clk = ~clk;

   mc_datapath_p dut (
      .clk(clk), .reset(reset), .ReadData(ReadData), .mem_ready(mem_ready),
      .mem_valid(mem_valid), .Adr(Adr), .WriteData(WriteData),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
      .FlagWrite(FlagWrite), .MemStart(MemStart), .AdrSrc(AdrSrc),
      .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .Instr(Instr), .ALUFlags(ALUFlags), .Stall(Stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_ext(input logic [31:0] ir, input logic [1:0] sel);
      int s;
      case (sel)
         2'd0: return {24'h0, ir[7:0]};
         2'd1: return {20'h0, ir[11:0]};
         2'd2: begin
            s = int'(ir[23:0]);
            if (s >= 8388608) s -= 16777216;
            return 32'(s * 4);
         end
         default: return 32'h0;
      endcase
   endfunction

   // Returns {N,Z,C,V,result} using wide integer arithmetic.
   function automatic logic [35:0] m_alu(input logic [2:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic shc);
      longint ux, uy, sx, sy, r, t, maxi, mini;
      logic [31:0] y32;
      logic c, v;
      ux = x; uy = y; sx = $signed(x); sy = $signed(y);
      maxi = 2147483647; mini = -maxi - 1;
      c = 1'b0; v = 1'b0; r = 0;
      case (op)
         3'd0: begin
            r = ux + uy; c = (r >= 64'd4294967296);
            t = sx + sy; v = (t > maxi) || (t < mini);
         end
         3'd1: begin
            r = ux - uy; c = (ux >= uy);
            t = sx - sy; v = (t > maxi) || (t < mini);
         end
         3'd2: begin r = ux & uy; c = shc; end
         3'd3: begin r = ux | uy; c = shc; end
         3'd4: begin r = ux ^ uy; c = shc; end
         3'd5: begin r = uy; c = shc; end
         default: begin r = ux; c = shc; end
      endcase
      y32 = r[31:0];
      return {y32[31], y32 == 32'h0, c, v, y32};
   endfunction

`ifdef DP_SHIFTER_EN
   function automatic logic [32:0] m_shift(input logic [31:0] b, input logic [31:0] ir);
      int n;
      logic [31:0] r;
      logic c;
      n = int'(ir[11:7]);
      if (n == 0) return {1'b0, b};
      case (ir[6:5])
         2'd0: begin r = b << n; c = b[32-n]; end
         2'd1: begin r = b >> n; c = b[n-1]; end
         2'd2: begin r = 32'($signed(b) >>> n); c = b[n-1]; end
         default: begin r = (b >> n) | (b << (32 - n)); c = r[31]; end
      endcase
      return {c, r};
   endfunction
`endif

   task automatic m_reset();
      m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_aluout = 0;
      m_data = 0; m_adr = 0; m_flags = 0; m_mv = 1'b0;
   endtask

   task automatic m_step();
      logic stall, shc;
      logic [3:0] ra1, ra2, wa;
      logic [31:0] rd1, rd2, sa, sb, bsh, result, live;
      logic [35:0] al;
      logic [32:0] sh;
      stall = m_mv && !mem_ready;
      ra1 = RegSrc[0] ? 4'd15 : m_ir[19:16];
      ra2 = RegSrc[1] ? m_ir[15:12] : m_ir[3:0];
      rd1 = (ra1 == 4'd15) ? m_pc : m_regs[ra1];
      rd2 = (ra2 == 4'd15) ? m_pc : m_regs[ra2];
      bsh = m_b; shc = 1'b0; sh = '0;
`ifdef DP_SHIFTER_EN
      sh = m_shift(m_b, m_ir); bsh = sh[31:0]; shc = (ALUSrcB == 2'd0) && sh[32];
`endif
      case (ALUSrcA) 2'd0: sa = m_a; 2'd1: sa = m_pc; default: sa = 0; endcase
      case (ALUSrcB)
         2'd0: sb = bsh;
         2'd1: sb = m_ext(m_ir, ImmSrc);
         2'd2: sb = 4;
         default: sb = 0;
      endcase
      al = m_alu(ALUControl, sa, sb, shc);
      case (ResultSrc)
         2'd0: result = m_aluout;
         2'd1: result = m_data;
         2'd2: result = m_pc + 4;
         default: result = al[31:0];
      endcase
      live = AdrSrc ? m_aluout : m_pc;
      if (!stall) begin
         if (RegWrite && RegSrc != 2'd3) begin
            wa = (RegSrc == 2'd0) ? m_ir[15:12] : (RegSrc == 2'd1) ? m_ir[3:0] : 4'd14;
            if (wa != 4'd15) m_regs[wa] = result;
         end
         if (PCWrite) m_pc = result;
         m_a = rd1; m_b = rd2; m_aluout = al[31:0];
         if (FlagWrite) m_flags = al[35:32];
      end
      if (m_mv) begin
         if (mem_ready) begin
            m_data = ReadData;
            if (IRWrite) m_ir = ReadData;
            m_mv = 1'b0;
         end
      end else if (MemStart) begin
         m_adr = live; m_mv = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mem_valid", mem_valid, m_mv);
         chk("Stall", Stall, m_mv && !mem_ready);
         chk("Adr", Adr, m_mv ? m_adr : (AdrSrc ? m_aluout : m_pc));
         chk("WriteData", WriteData, m_b);
         chk("Instr", Instr, m_ir);
         chk("ALUFlags", ALUFlags, m_flags);
      end
   end

   task automatic idle();
      PCWrite = 0; RegWrite = 0; IRWrite = 0; FlagWrite = 0; MemStart = 0; AdrSrc = 0;
      RegSrc = 0; ALUSrcA = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
      mem_ready = 0; ReadData = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      if (reset) m_reset();
      else m_step();
      #2;
   endtask

   task automatic mem_read(input logic [31:0] val, input logic irw);
      idle(); MemStart = 1; cyc();
      idle(); mem_ready = 1; ReadData = val; IRWrite = irw; cyc();
      idle();
   endtask

   task automatic wr_reg(input int k, input logic [31:0] val);
      mem_read(32'(k) << 12, 1'b1);
      mem_read(val, 1'b0);
      RegWrite = 1; RegSrc = 0; ResultSrc = 2'd1; cyc();
      idle();
   endtask

   task automatic rand_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         {PCWrite, RegWrite, IRWrite, FlagWrite, MemStart, AdrSrc} = 6'($urandom);
         RegSrc = 2'($urandom); ALUSrcA = 2'($urandom); ALUSrcB = 2'($urandom);
         ResultSrc = 2'($urandom); ImmSrc = 2'($urandom); ALUControl = 3'($urandom);
         mem_ready = ($urandom_range(0, 2) != 0);
         ReadData = $urandom;
         cyc();
      end
      idle(); mem_ready = 1; cyc();
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      @(posedge clk); #2;
      m_reset();
      #1;
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_adr", Adr, 0);
      chk("rst_instr", Instr, 0);
      chk("rst_flags", ALUFlags, 0);
      chk("rst_wdata", WriteData, 0);
      reset = 0;

      MemStart = 1; #1;
      chk("fetch_adr_start", Adr, 0);
      cyc();
      idle(); mem_ready = 1; ReadData = 32'hE2811005; IRWrite = 1; #1;
      chk("fetch_mem_valid", mem_valid, 1);
      chk("fetch_adr", Adr, 0);
      chk("fetch_no_stall", Stall, 0);
      cyc();
      idle(); #1;
      chk("fetch_instr", Instr, 32'hE2811005);
      chk("fetch_mv_clear", mem_valid, 0);

      for (int k = 0; k < 15; k++) begin
         case (k)
            1: wr_reg(k, 32'h7FFFFFFF);
            2: wr_reg(k, 32'd5);
            3: wr_reg(k, 32'd5);
            4: wr_reg(k, 32'h80000001);
            default: wr_reg(k, $urandom);
         endcase
      end
      cyc(); cyc();
      cmp_en = 1'b1;

      mem_read(32'h0001_0001, 1'b1); cyc();
      ALUSrcB = 2'd1; ImmSrc = 0; ALUControl = 3'd0; FlagWrite = 1; cyc();
      idle(); AdrSrc = 1; #1;
      chk("add_ovf_result", Adr, 32'h80000000);
      chk("add_ovf_nzcv", ALUFlags, 4'b1001);

      mem_read(32'h0002_0003, 1'b1); cyc();
      ALUControl = 3'd1; FlagWrite = 1; cyc();
      idle(); AdrSrc = 1; #1;
      chk("sub_zero_result", Adr, 32'h0);
      chk("sub_zero_nzcv", ALUFlags, 4'b0110);

`ifdef DP_SHIFTER_EN
      mem_read(32'h0000_00E4, 1'b1); cyc();
      ALUControl = 3'd5; cyc();
      idle(); AdrSrc = 1; #1;
      chk("ror1_result", Adr, 32'hC0000000);
      mem_read(32'h0002_0003, 1'b1);
      FlagWrite = 1; ALUControl = 3'd1; cyc();
      idle();
`endif

      idle(); PCWrite = 1; ResultSrc = 2'd2; cyc(); cyc();
      idle(); #1;
      chk("pc_plus8", Adr, 32'd8);

      MemStart = 1; cyc();
      for (int i = 0; i < 3; i++) begin
         idle();
         PCWrite = 1; RegWrite = 1; FlagWrite = 1; ResultSrc = 2'd2;
         ALUSrcA = 2'd2; ALUSrcB = 2'd2; #1;
         chk("wait_stall", Stall, 1);
         chk("wait_adr", Adr, 32'd8);
         cyc();
      end
      idle(); mem_ready = 1; ReadData = $urandom; #1;
      chk("wait_stall_end", Stall, 0);
      cyc();
      idle(); #1;
      chk("wait_pc_kept", Adr, 32'd8);
      chk("wait_flags_kept", ALUFlags, 4'b0110);

      rand_cycles(400);

      PCWrite = 1; ResultSrc = 2'd2; cyc();
      idle(); MemStart = 1; cyc();
      idle(); #1;
      chk("abort_pending", mem_valid, 1);
      reset = 1; m_reset(); #1;
      chk("abort_mv", mem_valid, 0);
      chk("abort_pc", Adr, 0);
      chk("abort_stall", Stall, 0);
      cyc();
      reset = 0;

      rand_cycles(400);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width (min 16, multiple of 8).
REQ-002 SHALL have parameter NREG, default 16, register count (power of 2, 4..32); register NREG-1 is the PC alias.
REQ-003 SHALL have parameter PC_INC, default 4, PC increment.
REQ-004 SHALL have ports clk in 1 (sole clock, rising edge) and reset in 1 (asynchronous, active-high).
REQ-005 SHALL have ports ReadData in DW (memory read data), mem_ready in 1 (memory completes access), mem_valid out 1 (memory access pending), Adr out DW (memory address), WriteData out DW (store data).
REQ-006 SHALL have control inputs PCWrite, RegWrite, IRWrite, FlagWrite, MemStart, AdrSrc (1 each), and RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc (2 each), and ALUControl (3).
REQ-007 SHALL have outputs Instr out DW (IR), ALUFlags out 4 (registered NZCV), and Stall out 1 (controller must hold state).

Function
REQ-008 SHALL hold PC, IR, A, B, ALUOut, Data, Flags and a memory-address register in flops; register file: NREG x DW, synchronous write, asynchronous read.
REQ-009 SHALL read register NREG-1 as current PC and ignore regfile writes to it; PC changes only via PCWrite.
REQ-010 SHALL drive RA1 = Instr[19:16] (RegSrc[0]=0) or NREG-1 (=1), and RA2 = Instr[3:0] (RegSrc[1]=0) or Instr[15:12] (=1), truncated to log2(NREG) bits.
REQ-011 SHALL drive write address Instr[15:12] (RegSrc=00), Instr[3:0] (01), NREG-2 link register (10), or no write (11).
REQ-012 SHALL select Result = ALUOut (ResultSrc 00), Data (01), PC+PC_INC (10), ALUResult (11); PC next value = Result.
REQ-013 SHALL select SrcA = A/PC/0 and SrcB = B/ExtImm/PC_INC for ALUSrcA/ALUSrcB 00/01/10; code 11 selects 0.
REQ-014 SHALL extend ImmSrc 00: zext Instr[7:0]; 01: zext Instr[11:0]; 10: sext(Instr[23:0])<<2; 11: 0; all to DW bits.
REQ-015 SHALL compute ALUControl 000 add, 001 sub (A-B), 010 and, 011 orr, 100 eor, 101 pass SrcB, 11x pass SrcA.
REQ-016 SHALL compute N = result MSB, Z = result all-zero, C = carry-out (add) or not-borrow (sub), V = signed overflow (add/sub); C,V = 0 for logic/pass ops.
REQ-017 SHALL load A, B, ALUOut every unstalled cycle, and Flags on unstalled cycles with FlagWrite=1.
REQ-018 SHALL on MemStart=1 (unstalled) latch address (AdrSrc ? ALUOut : PC) and set mem_valid=1 the next cycle; Adr drives the latched address while mem_valid=1, else the live mux.
REQ-019 SHALL keep mem_valid and Adr stable until the cycle mem_ready=1, then capture ReadData into Data (and IR if IRWrite=1) and clear mem_valid next cycle.
REQ-020 SHALL assert Stall = mem_valid & ~mem_ready combinationally; while Stall=1, suppress all PC, IR, regfile, Flags, A, B, ALUOut writes.
REQ-021 SHALL ignore MemStart while mem_valid=1 (no queued second access).
REQ-022 SHALL, when mem_ready=1 with mem_valid=0, ignore it (no capture).
REQ-023 SHALL drive WriteData from B, stable through the access.
REQ-024 SHALL give single-cycle access latency (mem_ready asserted in the first mem_valid cycle) with zero Stall cycles.

Reset
REQ-025 SHALL asynchronously clear PC, IR, A, B, ALUOut, Data, Flags, address register and mem_valid to 0 on reset=1; Stall=0 during reset.
REQ-026 SHALL abort a pending access on reset mid-transaction: mem_valid falls without waiting for mem_ready.
REQ-027 SHALL NOT reset register-file contents.

Configuration
REQ-028 SHALL, when DP_SHIFTER_EN is defined, pass B through a barrel shifter on ALUSrcB=00: type Instr[6:5] (LSL/LSR/ASR/ROR), amount Instr[11:7] modulo DW, C flag = last bit shifted out for logic ops when amount≠0.
REQ-029 SHALL, when DP_SHIFTER_EN is undefined, feed B unshifted, with no shifter logic.

Verification
REQ-030 Reset, then MemStart with AdrSrc=0, mem_ready=1 first cycle, ReadData=0xE2811005, IRWrite=1 -> Adr=0, Instr=0xE2811005, Stall never 1.
REQ-031 MemStart, mem_ready held low 3 cycles -> Stall=1 for 3 cycles, PC/Flags/regfile unchanged despite PCWrite=RegWrite=FlagWrite=1, Adr constant.
REQ-032 A=0x7FFFFFFF, ExtImm=1, ALUControl=000, FlagWrite=1 -> ALUOut=0x80000000, NZCV=1001.
REQ-033 A=5, B=5, ALUControl=001 -> ALUOut=0, NZCV=0110.
REQ-034 reset asserted during stalled access -> mem_valid=0 and PC=0 immediately, before next clk edge.
REQ-035 DP_SHIFTER_EN defined, B=0x80000001, Instr[11:7]=1, Instr[6:5]=11, ALUControl=101 -> ALUOut=0xC0000000.
